// File: rtl/axi_mm_pipe_pkg.sv
// Shared field widths, skid states and link-word width helpers
// for the AXI4-MM slave-side link mapper.
package axi_mm_pipe_pkg;

  localparam int SIZE_W  = 3;
  localparam int LEN_W   = 8;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_e;

  function automatic int ar_w(input int id_w, input int addr_w);
    return id_w + SIZE_W + LEN_W + BURST_W + addr_w;
  endfunction

  function automatic int w_w(input int id_w, input int data_w);
    return id_w + data_w + data_w / 8 + 1;
  endfunction

  function automatic int r_w(input int id_w, input int data_w);
    return id_w + data_w + 1 + RESP_W;
  endfunction

  function automatic int b_w(input int id_w);
    return id_w + RESP_W;
  endfunction

endpackage

// File: rtl/axi_mm_skid_buf.sv
// Two-entry registered skid stage (or plain wire-through),
// readies held low until the first clock after reset.
module axi_mm_skid_buf
  import axi_mm_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REG_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic rst_done_q;
  logic rst_done_d;

  assign rst_done_d = 1'b1;

  // Reset-done marker: low in reset, high from the first edge after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done_q <= 1'b0;
    else        rst_done_q <= rst_done_d;
  end

  if (REG_MODE != 0) begin : g_reg
    skid_state_e            state_q, state_d;
    logic [1:0][WIDTH-1:0]  mem_q, mem_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   push, pop;

    assign in_ready  = rst_done_q & (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state, storage write and pointer advance
    always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      unique case (state_q)
        S_EMPTY: if (push) state_d = S_ONE;
        S_ONE: begin
          if (push && !pop)      state_d = S_FULL;
          else if (!push && pop) state_d = S_EMPTY;
        end
        S_FULL:  if (pop) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end

    // State, storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= S_EMPTY;
        mem_q    <= '0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        mem_q    <= mem_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
      end
    end
  end else begin : g_pass
    assign in_ready  = rst_done_q & out_ready;
    assign out_valid = rst_done_q & in_valid;
    assign out_data  = in_data;
  end

endmodule

// File: rtl/axi_mm_slave_name_pipe.sv
// Slave-side AXI4-MM link mapper: unpacks AR/AW/W link words,
// packs R/B responses, throttles AR/AW on outstanding counts.
module axi_mm_slave_name_pipe
  import axi_mm_pipe_pkg::*;
#(
  parameter int ID_W     = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int REG_MODE = 1,
  parameter int MAX_OUT  = 4
) (
  input  logic                              clk_wr,
  input  logic                              rst_wr_n,
  input  logic                              user_ar_vld,
  input  logic [ar_w(ID_W,ADDR_W)-1:0]      rxfifo_ar_data,
  output logic                              user_ar_ready,
  input  logic                              user_aw_vld,
  input  logic [ar_w(ID_W,ADDR_W)-1:0]      rxfifo_aw_data,
  output logic                              user_aw_ready,
  input  logic                              user_w_vld,
  input  logic [w_w(ID_W,DATA_W)-1:0]       rxfifo_w_data,
  output logic                              user_w_ready,
  output logic                              user_r_vld,
  output logic [r_w(ID_W,DATA_W)-1:0]       txfifo_r_data,
  input  logic                              user_r_ready,
  output logic                              user_b_vld,
  output logic [b_w(ID_W)-1:0]              txfifo_b_data,
  input  logic                              user_b_ready,
  output logic [ID_W-1:0]                   user_arid,
  output logic [SIZE_W-1:0]                 user_arsize,
  output logic [LEN_W-1:0]                  user_arlen,
  output logic [BURST_W-1:0]                user_arburst,
  output logic [ADDR_W-1:0]                 user_araddr,
  output logic                              user_arvalid,
  input  logic                              user_arready,
  output logic [ID_W-1:0]                   user_awid,
  output logic [SIZE_W-1:0]                 user_awsize,
  output logic [LEN_W-1:0]                  user_awlen,
  output logic [BURST_W-1:0]                user_awburst,
  output logic [ADDR_W-1:0]                 user_awaddr,
  output logic                              user_awvalid,
  input  logic                              user_awready,
  output logic [ID_W-1:0]                   user_wid,
  output logic [DATA_W-1:0]                 user_wdata,
  output logic [DATA_W/8-1:0]               user_wstrb,
  output logic                              user_wlast,
  output logic                              user_wvalid,
  input  logic                              user_wready,
  input  logic [ID_W-1:0]                   user_rid,
  input  logic [DATA_W-1:0]                 user_rdata,
  input  logic                              user_rlast,
  input  logic [RESP_W-1:0]                 user_rresp,
  input  logic                              user_rvalid,
  output logic                              user_rready,
  input  logic [ID_W-1:0]                   user_bid,
  input  logic [RESP_W-1:0]                 user_bresp,
  input  logic                              user_bvalid,
  output logic                              user_bready,
  output logic [$clog2(MAX_OUT+1)-1:0]      rd_outstanding,
  output logic [$clog2(MAX_OUT+1)-1:0]      wr_outstanding,
  output logic                              err_rd_unexp,
  output logic                              err_wr_unexp
);

  localparam int SW       = DATA_W / 8;
  localparam int CW       = $clog2(MAX_OUT + 1);
  localparam int AXW      = ar_w(ID_W, ADDR_W);
  localparam int WW       = w_w(ID_W, DATA_W);
  localparam int RW       = r_w(ID_W, DATA_W);
  localparam int BW       = b_w(ID_W);
  localparam int AX_SIZE  = ID_W;
  localparam int AX_LEN   = AX_SIZE + SIZE_W;
  localparam int AX_BURST = AX_LEN + LEN_W;
  localparam int AX_ADDR  = AX_BURST + BURST_W;
  localparam int W_DATA   = ID_W;
  localparam int W_STRB   = W_DATA + DATA_W;
  localparam int W_LAST   = W_STRB + SW;
  localparam int R_LAST   = ID_W + DATA_W;

  logic           ar_s_valid, ar_s_ready;
  logic [AXW-1:0] ar_s_data;
  logic           aw_s_valid, aw_s_ready;
  logic [AXW-1:0] aw_s_data;
  logic           w_s_valid;
  logic [WW-1:0]  w_s_data;
  logic [RW-1:0]  r_pack;
  logic [BW-1:0]  b_pack;
  logic           rd_ok, wr_ok;
  logic           rd_inc, rd_dec, wr_inc, wr_dec;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic           err_rd_q, err_rd_d;
  logic           err_wr_q, err_wr_d;

  assign rd_ok = (rd_cnt_q < CW'(MAX_OUT));
  assign wr_ok = (wr_cnt_q < CW'(MAX_OUT));

  axi_mm_skid_buf #(.WIDTH(AXW), .REG_MODE(REG_MODE)) u_ar (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_valid(user_ar_vld), .in_ready(user_ar_ready),
    .in_data(rxfifo_ar_data),
    .out_valid(ar_s_valid), .out_ready(ar_s_ready),
    .out_data(ar_s_data)
  );

  axi_mm_skid_buf #(.WIDTH(AXW), .REG_MODE(REG_MODE)) u_aw (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_valid(user_aw_vld), .in_ready(user_aw_ready),
    .in_data(rxfifo_aw_data),
    .out_valid(aw_s_valid), .out_ready(aw_s_ready),
    .out_data(aw_s_data)
  );

  axi_mm_skid_buf #(.WIDTH(WW), .REG_MODE(REG_MODE)) u_w (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_valid(user_w_vld), .in_ready(user_w_ready),
    .in_data(rxfifo_w_data),
    .out_valid(w_s_valid), .out_ready(user_wready),
    .out_data(w_s_data)
  );

  axi_mm_skid_buf #(.WIDTH(RW), .REG_MODE(REG_MODE)) u_r (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_valid(user_rvalid), .in_ready(user_rready),
    .in_data(r_pack),
    .out_valid(user_r_vld), .out_ready(user_r_ready),
    .out_data(txfifo_r_data)
  );

  axi_mm_skid_buf #(.WIDTH(BW), .REG_MODE(REG_MODE)) u_b (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_valid(user_bvalid), .in_ready(user_bready),
    .in_data(b_pack),
    .out_valid(user_b_vld), .out_ready(user_b_ready),
    .out_data(txfifo_b_data)
  );

  assign user_arvalid = ar_s_valid & rd_ok;
  assign ar_s_ready   = user_arready & rd_ok;
  assign user_arid    = ar_s_data[0 +: ID_W];
  assign user_arsize  = ar_s_data[AX_SIZE +: SIZE_W];
  assign user_arlen   = ar_s_data[AX_LEN +: LEN_W];
  assign user_arburst = ar_s_data[AX_BURST +: BURST_W];
  assign user_araddr  = ar_s_data[AX_ADDR +: ADDR_W];

  assign user_awvalid = aw_s_valid & wr_ok;
  assign aw_s_ready   = user_awready & wr_ok;
  assign user_awid    = aw_s_data[0 +: ID_W];
  assign user_awsize  = aw_s_data[AX_SIZE +: SIZE_W];
  assign user_awlen   = aw_s_data[AX_LEN +: LEN_W];
  assign user_awburst = aw_s_data[AX_BURST +: BURST_W];
  assign user_awaddr  = aw_s_data[AX_ADDR +: ADDR_W];

  assign user_wvalid  = w_s_valid;
  assign user_wid     = w_s_data[0 +: ID_W];
  assign user_wdata   = w_s_data[W_DATA +: DATA_W];
  assign user_wstrb   = w_s_data[W_STRB +: SW];
  assign user_wlast   = w_s_data[W_LAST];

  assign r_pack = {user_rresp, user_rlast, user_rdata, user_rid};
  assign b_pack = {user_bresp, user_bid};

  assign rd_inc = user_arvalid & user_arready;
  assign rd_dec = user_r_vld & user_r_ready & txfifo_r_data[R_LAST];
  assign wr_inc = user_awvalid & user_awready;
  assign wr_dec = user_b_vld & user_b_ready;

  // Outstanding counters; a retire at zero holds and raises a sticky error
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_rd_d = err_rd_q;
    err_wr_d = err_wr_q;
    if (rd_inc && !rd_dec) begin
      rd_cnt_d = rd_cnt_q + CW'(1);
    end else if (!rd_inc && rd_dec) begin
      if (rd_cnt_q == '0) err_rd_d = 1'b1;
      else                rd_cnt_d = rd_cnt_q - CW'(1);
    end
    if (wr_inc && !wr_dec) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
    end else if (!wr_inc && wr_dec) begin
      if (wr_cnt_q == '0) err_wr_d = 1'b1;
      else                wr_cnt_d = wr_cnt_q - CW'(1);
    end
  end

  // Counter and error-flag registers
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_rd_q <= 1'b0;
      err_wr_q <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_rd_q <= err_rd_d;
      err_wr_q <= err_wr_d;
    end
  end

  assign rd_outstanding = rd_cnt_q;
  assign wr_outstanding = wr_cnt_q;
  assign err_rd_unexp   = err_rd_q;
  assign err_wr_unexp   = err_wr_q;

endmodule

// File: tb/tb_axi_mm_slave_name_pipe.sv
// Self-checking bench for axi_mm_slave_name_pipe (defaults,
// REG_MODE=1, MAX_OUT=4) with per-channel scoreboards.
module tb_axi_mm_slave_name_pipe;

  typedef struct {
    logic [1:0]  id;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] addr;
  } ax_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [36:0] exp;
  } r_vec_t;

  logic        clk_wr, rst_wr_n;
  logic        user_ar_vld, user_ar_ready;
  logic [46:0] rxfifo_ar_data;
  logic        user_aw_vld, user_aw_ready;
  logic [46:0] rxfifo_aw_data;
  logic        user_w_vld, user_w_ready;
  logic [38:0] rxfifo_w_data;
  logic        user_r_vld, user_r_ready;
  logic [36:0] txfifo_r_data;
  logic        user_b_vld, user_b_ready;
  logic [3:0]  txfifo_b_data;
  logic [1:0]  user_arid, user_arburst;
  logic [2:0]  user_arsize;
  logic [7:0]  user_arlen;
  logic [31:0] user_araddr;
  logic        user_arvalid, user_arready;
  logic [1:0]  user_awid, user_awburst;
  logic [2:0]  user_awsize;
  logic [7:0]  user_awlen;
  logic [31:0] user_awaddr;
  logic        user_awvalid, user_awready;
  logic [1:0]  user_wid;
  logic [31:0] user_wdata;
  logic [3:0]  user_wstrb;
  logic        user_wlast, user_wvalid, user_wready;
  logic [1:0]  user_rid, user_rresp;
  logic [31:0] user_rdata;
  logic        user_rlast, user_rvalid, user_rready;
  logic [1:0]  user_bid, user_bresp;
  logic        user_bvalid, user_bready;
  logic [2:0]  rd_outstanding, wr_outstanding;
  logic        err_rd_unexp, err_wr_unexp;

  int checks   = 0;
  int failures = 0;

  ax_t         arq[$];
  ax_t         awq[$];
  w_t          wq[$];
  logic [36:0] rq[$];
  logic [3:0]  bq[$];

  r_vec_t rtab[6];
  w_t     wtab[8];
  ax_t    a0, a1;
  bit     done_flag;

  axi_mm_slave_name_pipe #(
    .ID_W(2), .ADDR_W(32), .DATA_W(32),
    .REG_MODE(1), .MAX_OUT(4)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .user_ar_vld(user_ar_vld), .rxfifo_ar_data(rxfifo_ar_data),
    .user_ar_ready(user_ar_ready),
    .user_aw_vld(user_aw_vld), .rxfifo_aw_data(rxfifo_aw_data),
    .user_aw_ready(user_aw_ready),
    .user_w_vld(user_w_vld), .rxfifo_w_data(rxfifo_w_data),
    .user_w_ready(user_w_ready),
    .user_r_vld(user_r_vld), .txfifo_r_data(txfifo_r_data),
    .user_r_ready(user_r_ready),
    .user_b_vld(user_b_vld), .txfifo_b_data(txfifo_b_data),
    .user_b_ready(user_b_ready),
    .user_arid(user_arid), .user_arsize(user_arsize),
    .user_arlen(user_arlen), .user_arburst(user_arburst),
    .user_araddr(user_araddr), .user_arvalid(user_arvalid),
    .user_arready(user_arready),
    .user_awid(user_awid), .user_awsize(user_awsize),
    .user_awlen(user_awlen), .user_awburst(user_awburst),
    .user_awaddr(user_awaddr), .user_awvalid(user_awvalid),
    .user_awready(user_awready),
    .user_wid(user_wid), .user_wdata(user_wdata),
    .user_wstrb(user_wstrb), .user_wlast(user_wlast),
    .user_wvalid(user_wvalid), .user_wready(user_wready),
    .user_rid(user_rid), .user_rdata(user_rdata),
    .user_rlast(user_rlast), .user_rresp(user_rresp),
    .user_rvalid(user_rvalid), .user_rready(user_rready),
    .user_bid(user_bid), .user_bresp(user_bresp),
    .user_bvalid(user_bvalid), .user_bready(user_bready),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_rd_unexp(err_rd_unexp), .err_wr_unexp(err_wr_unexp)
  );

  initial begin
    clk_wr = 1'b0;
    forever #5 clk_wr = ~clk_wr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [46:0] pack_ax(input ax_t a);
    return {a.addr, a.burst, a.len, a.size, a.id};
  endfunction

  function automatic logic [38:0] pack_w(input w_t w);
    return {w.last, w.strb, w.data, w.id};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=beat required=none", nm);
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic send_ar(input ax_t a);
    int n = 0;
    user_ar_vld    = 1'b1;
    rxfifo_ar_data = pack_ax(a);
    do begin @(negedge clk_wr); n++; end
    while (!user_ar_ready && n < 50);
    chk("ar_accept", 64'(user_ar_ready), 64'd1);
    if (user_ar_ready) arq.push_back(a);
    tick();
    user_ar_vld = 1'b0;
  endtask

  task automatic send_aw(input ax_t a);
    int n = 0;
    user_aw_vld    = 1'b1;
    rxfifo_aw_data = pack_ax(a);
    do begin @(negedge clk_wr); n++; end
    while (!user_aw_ready && n < 50);
    chk("aw_accept", 64'(user_aw_ready), 64'd1);
    if (user_aw_ready) awq.push_back(a);
    tick();
    user_aw_vld = 1'b0;
  endtask

  task automatic send_w(input w_t w);
    int n = 0;
    user_w_vld    = 1'b1;
    rxfifo_w_data = pack_w(w);
    do begin @(negedge clk_wr); n++; end
    while (!user_w_ready && n < 50);
    chk("w_accept", 64'(user_w_ready), 64'd1);
    if (user_w_ready) wq.push_back(w);
    tick();
    user_w_vld = 1'b0;
  endtask

  task automatic send_r(input logic [1:0] id, input logic [31:0] d,
                        input logic l, input logic [1:0] rs);
    int n = 0;
    user_rvalid = 1'b1;
    user_rid    = id;
    user_rdata  = d;
    user_rlast  = l;
    user_rresp  = rs;
    do begin @(negedge clk_wr); n++; end
    while (!user_rready && n < 50);
    chk("r_accept", 64'(user_rready), 64'd1);
    if (user_rready) rq.push_back({rs, l, d, id});
    tick();
    user_rvalid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] id, input logic [1:0] rs);
    int n = 0;
    user_bvalid = 1'b1;
    user_bid    = id;
    user_bresp  = rs;
    do begin @(negedge clk_wr); n++; end
    while (!user_bready && n < 50);
    chk("b_accept", 64'(user_bready), 64'd1);
    if (user_bready) bq.push_back({rs, id});
    tick();
    user_bvalid = 1'b0;
  endtask

  always @(negedge clk_wr) begin
    if (rst_wr_n && user_arvalid && user_arready) begin
      if (arq.size() == 0) extra("ar_extra");
      else chk("ar_beat",
               64'({user_araddr, user_arburst, user_arlen,
                    user_arsize, user_arid}),
               64'(pack_ax(arq.pop_front())));
    end
    if (rst_wr_n && user_awvalid && user_awready) begin
      if (awq.size() == 0) extra("aw_extra");
      else chk("aw_beat",
               64'({user_awaddr, user_awburst, user_awlen,
                    user_awsize, user_awid}),
               64'(pack_ax(awq.pop_front())));
    end
    if (rst_wr_n && user_wvalid && user_wready) begin
      if (wq.size() == 0) extra("w_extra");
      else chk("w_beat",
               64'({user_wlast, user_wstrb, user_wdata, user_wid}),
               64'(pack_w(wq.pop_front())));
    end
    if (rst_wr_n && user_r_vld && user_r_ready) begin
      if (rq.size() == 0) extra("r_extra");
      else chk("r_beat", 64'(txfifo_r_data), 64'(rq.pop_front()));
    end
    if (rst_wr_n && user_b_vld && user_b_ready) begin
      if (bq.size() == 0) extra("b_extra");
      else chk("b_beat", 64'(txfifo_b_data), 64'(bq.pop_front()));
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      rtab[i].id   = 2'(i);
      rtab[i].data = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0013);
      rtab[i].last = 1'b0;
      rtab[i].resp = 2'(i + 1);
      rtab[i].exp  = {rtab[i].resp, rtab[i].last,
                      rtab[i].data, rtab[i].id};
    end
    for (int i = 0; i < 8; i++) begin
      wtab[i].id   = 2'(3 - (i % 4));
      wtab[i].data = 32'hC0DE_0000 | (32'(i) << 4) | 32'(i);
      wtab[i].strb = 4'(i * 3 + 1);
      wtab[i].last = ((i % 4) == 3);
    end

    rst_wr_n       = 1'b1;
    user_ar_vld    = 1'b0;
    rxfifo_ar_data = '0;
    user_aw_vld    = 1'b0;
    rxfifo_aw_data = '0;
    user_w_vld     = 1'b0;
    rxfifo_w_data  = '0;
    user_r_ready   = 1'b1;
    user_b_ready   = 1'b1;
    user_arready   = 1'b0;
    user_awready   = 1'b0;
    user_wready    = 1'b0;
    user_rid       = '0;
    user_rdata     = '0;
    user_rlast     = 1'b0;
    user_rresp     = '0;
    user_rvalid    = 1'b0;
    user_bid       = '0;
    user_bresp     = '0;
    user_bvalid    = 1'b0;
    done_flag      = 1'b0;

    #1 rst_wr_n = 1'b0;
    #2;
    chk("rst_ar_ready", 64'(user_ar_ready), 64'd0);
    chk("rst_w_ready", 64'(user_w_ready), 64'd0);
    chk("rst_rready", 64'(user_rready), 64'd0);
    chk("rst_arvalid", 64'(user_arvalid), 64'd0);
    chk("rst_r_vld", 64'(user_r_vld), 64'd0);
    chk("rst_b_vld", 64'(user_b_vld), 64'd0);
    chk("rst_araddr", 64'(user_araddr), 64'd0);
    chk("rst_r_data", 64'(txfifo_r_data), 64'd0);
    chk("rst_rd_cnt", 64'(rd_outstanding), 64'd0);
    chk("rst_errs", 64'({err_rd_unexp, err_wr_unexp}), 64'd0);
    #9 rst_wr_n = 1'b1;
    #1;
    chk("rdy_before_edge", 64'(user_ar_ready), 64'd0);
    tick();
    chk("rdy_after_edge",
        64'({user_ar_ready, user_aw_ready, user_w_ready,
             user_rready, user_bready}), 64'h1f);

    a0 = '{2'b10, 3'd2, 8'd3, 2'b01, 32'h1234_5678};
    chk("ar_idle_valid", 64'(user_arvalid), 64'd0);
    send_ar(a0);
    chk("ar_lat_valid", 64'(user_arvalid), 64'd1);
    chk("ar_id", 64'(user_arid), 64'd2);
    chk("ar_size", 64'(user_arsize), 64'd2);
    chk("ar_len", 64'(user_arlen), 64'd3);
    chk("ar_burst", 64'(user_arburst), 64'd1);
    chk("ar_addr", 64'(user_araddr), 64'h1234_5678);
    user_arready = 1'b1;
    tick();
    chk("ar_cnt_one", 64'(rd_outstanding), 64'd1);
    chk("ar_drained", 64'(user_arvalid), 64'd0);
    send_r(2'b10, 32'hDEAD_BEEF, 1'b1, 2'b00);
    repeat (3) tick();
    chk("rd_cnt_back0", 64'(rd_outstanding), 64'd0);

    for (int i = 0; i < 5; i++) begin
      a1 = '{2'(i), 3'd2, 8'(i), 2'b01, 32'h4000_0000 + 32'(i * 64)};
      send_ar(a1);
    end
    repeat (4) tick();
    chk("thr_cnt_max", 64'(rd_outstanding), 64'd4);
    chk("thr_arvalid", 64'(user_arvalid), 64'd0);
    chk("thr_held", 64'(arq.size()), 64'd1);
    send_r(2'd0, 32'h0000_1111, 1'b1, 2'b00);
    repeat (4) tick();
    chk("thr_cnt_refill", 64'(rd_outstanding), 64'd4);
    chk("thr_issued", 64'(arq.size()), 64'd0);
    for (int i = 0; i < 4; i++)
      send_r(2'(i + 1), 32'h2222_0000 + 32'(i), 1'b1, 2'b00);
    repeat (3) tick();
    chk("thr_cnt_zero", 64'(rd_outstanding), 64'd0);

    send_ar(a0);
    send_ar(a0);
    repeat (3) tick();
    chk("sim_cnt_two", 64'(rd_outstanding), 64'd2);
    user_arready = 1'b0;
    send_ar(a0);
    user_r_ready = 1'b0;
    send_r(2'd1, 32'h3333_3333, 1'b1, 2'b01);
    tick();
    chk("sim_pre", 64'(rd_outstanding), 64'd2);
    chk("sim_both_vld", 64'({user_arvalid, user_r_vld}), 64'd3);
    user_arready = 1'b1;
    user_r_ready = 1'b1;
    tick();
    chk("sim_same", 64'(rd_outstanding), 64'd2);
    chk("sim_both_gone", 64'({user_arvalid, user_r_vld}), 64'd0);
    tick();
    chk("sim_after", 64'(rd_outstanding), 64'd2);
    send_r(2'd2, 32'h4444_0000, 1'b1, 2'b00);
    send_r(2'd3, 32'h4444_0001, 1'b1, 2'b00);
    repeat (3) tick();
    chk("sim_drain", 64'(rd_outstanding), 64'd0);
    chk("no_rd_err", 64'(err_rd_unexp), 64'd0);

    fork
      begin
        for (int i = 0; i < 6; i++)
          send_r(rtab[i].id, rtab[i].data, rtab[i].last, rtab[i].resp);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk_wr);
          if (rq.size() == 0) break;
        end
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          user_r_ready = 1'($urandom_range(0, 1));
          tick();
        end
        user_r_ready = 1'b1;
      end
    join
    repeat (6) tick();
    chk("r_tab_drained", 64'(rq.size()), 64'd0);

    a1 = '{2'b01, 3'd3, 8'd15, 2'b10, 32'h8000_0F00};
    user_awready = 1'b1;
    send_aw(a1);
    repeat (3) tick();
    chk("aw_cnt_one", 64'(wr_outstanding), 64'd1);
    send_b(2'b01, 2'b00);
    repeat (3) tick();
    chk("aw_cnt_zero", 64'(wr_outstanding), 64'd0);
    chk("wr_err_clean", 64'(err_wr_unexp), 64'd0);
    send_b(2'b11, 2'b10);
    repeat (3) tick();
    chk("wr_err_set", 64'(err_wr_unexp), 64'd1);
    chk("wr_err_cnt", 64'(wr_outstanding), 64'd0);
    repeat (5) tick();
    chk("wr_err_sticky", 64'(err_wr_unexp), 64'd1);

    user_wready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_w(wtab[i]);
      end
      begin
        repeat (8) tick();
        chk("w_bp_ready", 64'(user_w_ready), 64'd0);
        chk("w_bp_count", 64'(wq.size()), 64'd2);
        chk("w_bp_valid", 64'(user_wvalid), 64'd1);
        user_wready = 1'b1;
      end
    join
    repeat (4) tick();
    chk("w_bp_drained", 64'(wq.size()), 64'd0);

    done_flag = 1'b0;
    fork
      begin
        for (int i = 4; i < 8; i++) send_w(wtab[i]);
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          user_wready = 1'($urandom_range(0, 1));
          tick();
        end
        user_wready = 1'b1;
      end
    join
    repeat (6) tick();
    chk("w_rand_drained", 64'(wq.size()), 64'd0);

    send_ar(a0);
    repeat (3) tick();
    user_arready = 1'b0;
    send_ar(a0);
    user_wready = 1'b0;
    send_w(wtab[0]);
    send_w(wtab[1]);
    tick();
    chk("pre_rst_cnt", 64'(rd_outstanding), 64'd1);
    chk("pre_rst_w_full", 64'(user_w_ready), 64'd0);
    @(negedge clk_wr);
    #2 rst_wr_n = 1'b0;
    #1;
    chk("mid_rst_valids",
        64'({user_arvalid, user_wvalid, user_r_vld, user_b_vld}),
        64'd0);
    chk("mid_rst_readies",
        64'({user_ar_ready, user_w_ready, user_rready}), 64'd0);
    chk("mid_rst_cnt", 64'(rd_outstanding), 64'd0);
    arq.delete();
    wq.delete();
    user_wready  = 1'b1;
    user_arready = 1'b1;
    @(posedge clk_wr);
    #3 rst_wr_n = 1'b1;
    #1;
    chk("rel_rdy_low", 64'(user_w_ready), 64'd0);
    tick();
    chk("rel_rdy_high",
        64'({user_ar_ready, user_aw_ready, user_w_ready,
             user_rready, user_bready}), 64'h1f);
    chk("rel_cnts", 64'({rd_outstanding, wr_outstanding}), 64'd0);
    chk("rel_errs", 64'({err_rd_unexp, err_wr_unexp}), 64'd0);
    chk("rel_no_valid", 64'({user_arvalid, user_wvalid}), 64'd0);
    repeat (3) tick();
    chk("end_queues",
        64'(arq.size() + awq.size() + wq.size() + rq.size() + bq.size()),
        64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
